// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and 8N1 frame constants.
// Imported by the receive FIFO and the buffered receiver top.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // 12 MHz clock, 9600 baud
    localparam int BIT_PERIOD_DEFAULT = 1250;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock first-word-fall-through FIFO for received bytes.
// A push is accepted when full only if a pop happens in the same cycle.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;

    // empty FIFO presents zero rather than stale storage
    assign rdata = empty ? '0 : mem[rd_ptr];

    // byte storage, written at the tail
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a FWFT byte FIFO with overrun reporting.
// Define UART_RX_FRAME_CHECK_EN to drop bad-stop frames and wait out breaks.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int BIT_PERIOD = BIT_PERIOD_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_pin,
    input  logic                        ack,
    output logic                        ready,
    output logic [7:0]                  data,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overrun,
    output logic                        frame_err
);

    localparam int BW = $clog2(BIT_PERIOD);
    localparam logic [BW-1:0] HALF_M1 = BW'(BIT_PERIOD / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(BIT_PERIOD - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic                 sync1;
    logic                 rx_s;
    rx_state_e            state, state_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [2:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 push_req;
    logic                 fe_raw;
    logic                 fifo_empty;
    logic                 fifo_ovf;
    logic                 armed;

`ifdef UART_RX_FRAME_CHECK_EN
    logic armed_n;
`else
    assign armed = 1'b1;
`endif

    // two-flop synchronizer, idles high like the line
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_pin;
            rx_s  <= sync1;
        end
    end

    // receiver state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcnt  <= '0;
            idx   <= '0;
            shreg <= '0;
`ifdef UART_RX_FRAME_CHECK_EN
            armed <= 1'b1;
`endif
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
`ifdef UART_RX_FRAME_CHECK_EN
            armed <= armed_n;
`endif
        end
    end

    // next-state: mid-bit sampling from the start-bit centre
    always_comb begin
        state_n  = state;
        bcnt_n   = bcnt;
        idx_n    = idx;
        shreg_n  = shreg;
        push_req = 1'b0;
        fe_raw   = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        armed_n  = armed;
`endif
        unique case (state)
            IDLE: begin
                bcnt_n = '0;
`ifdef UART_RX_FRAME_CHECK_EN
                if (rx_s) begin
                    armed_n = 1'b1;
                end
`endif
                if (!rx_s && armed) begin
                    state_n = START;
                end
            end
            START: begin
                if (bcnt == HALF_M1) begin
                    bcnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        idx_n   = '0;
                    end
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            DATA: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n       = '0;
                    shreg_n[idx] = rx_s;
                    if (idx == LAST_IDX) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            STOP: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n  = '0;
                    state_n = IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                    if (rx_s) begin
                        push_req = 1'b1;
                    end else begin
                        fe_raw  = 1'b1;
                        armed_n = 1'b0;
                    end
`else
                    push_req = 1'b1;
`endif
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                bcnt_n  = '0;
            end
        endcase
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .wdata    (shreg_n),
        .pop      (ack),
        .rdata    (data),
        .count    (count),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    assign ready     = !fifo_empty;
    assign overrun   = fifo_ovf && !rst;
    assign frame_err = fe_raw && !rst;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered at 16 clk/bit, 4-entry FIFO.
// Frame timing and FIFO contents come from a queue-level reference model.
module tb_uart_rx_buffered;

    localparam int BP = 16;
    localparam int D  = 4;

`ifdef UART_RX_FRAME_CHECK_EN
    localparam logic BAD_STOP_PUSH = 1'b0;
    localparam int   BAD_STOP_FE   = 1;
`else
    localparam logic BAD_STOP_PUSH = 1'b1;
    localparam int   BAD_STOP_FE   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic       ack = 1'b0;
    logic       ready;
    logic [7:0] data;
    logic [2:0] count;
    logic       overrun;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int ovr_seen = 0;
    int fe_seen = 0;

    typedef struct {
        logic [7:0] val;
        logic       stop;
        logic       exp_push;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] q[$];

    uart_rx_buffered #(
        .BIT_PERIOD (BP),
        .FIFO_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_pin    (rx_pin),
        .ack       (ack),
        .ready     (ready),
        .data      (data),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun) ovr_seen++;
        if (frame_err) fe_seen++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_pin = 1'b0;
        repeat (BP) tick();
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (BP) tick();
        end
        rx_pin = stop;
        repeat (BP) tick();
        rx_pin = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_ready"}, ready, 1);
        check({name, "_data"}, data, exp);
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, ready, 0);
        check({name, "_count"}, count, 0);
        check({name, "_data"}, data, 0);
        check({name, "_overrun"}, overrun, 0);
        check({name, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        int f0;
        int exp_ovr;
        int n;
        int p;
        logic [7:0] b;

        tbl[0] = '{8'hA5, 1'b1, 1'b1};
        tbl[1] = '{8'h00, 1'b1, 1'b1};
        tbl[2] = '{8'hFF, 1'b1, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, BAD_STOP_PUSH};
        tbl[4] = '{8'h80, 1'b1, 1'b1};
        tbl[5] = '{8'h01, 1'b0, BAD_STOP_PUSH};

        // reset values, during and after reset
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        tick();
        check_reset_outputs("rst_rel");

        // ack while empty is ignored
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check("ack_empty_count", count, 0);
        check("ack_empty_ready", ready, 0);

        // single byte, exact ready timing
        fork
            send_frame(8'h41, 1'b1);
            begin
                repeat (154) tick();
                check("b41_pre_ready", ready, 0);
                tick();
                check("b41_ready", ready, 1);
                check("b41_data", data, 8'h41);
                check("b41_count", count, 1);
            end
        join
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("b41_pop_ready", ready, 0);
        check("b41_pop_count", count, 0);

        // three back-to-back frames
        send_frame(8'h31, 1'b1);
        send_frame(8'h0D, 1'b1);
        send_frame(8'h20, 1'b1);
        check("b2b_count", count, 3);
        pop_check("b2b_0", 8'h31);
        pop_check("b2b_1", 8'h0D);
        pop_check("b2b_2", 8'h20);
        check("b2b_empty", count, 0);

        // overrun on the fifth byte only
        o0 = ovr_seen;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check("ovr_before", ovr_seen - o0, 0);
        send_frame(8'h05, 1'b1);
        check("ovr_count", count, 4);
        check("ovr_pulses", ovr_seen - o0, 1);
        for (int i = 1; i <= 4; i++) pop_check("ovr_pop", 8'(i));

        // pop in the exact push cycle while full
        for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b1);
        check("full_count", count, 4);
        o0 = ovr_seen;
        fork
            send_frame(8'hB0, 1'b1);
            begin
                repeat (154) tick();
                ack = 1'b1;
                tick();
                ack = 1'b0;
            end
        join
        check("pp_count", count, 4);
        check("pp_no_ovr", ovr_seen - o0, 0);
        pop_check("pp_0", 8'hA1);
        pop_check("pp_1", 8'hA2);
        pop_check("pp_2", 8'hA3);
        pop_check("pp_3", 8'hB0);

        // short glitch is rejected, receiver still usable
        rx_pin = 1'b0;
        repeat (4) tick();
        rx_pin = 1'b1;
        repeat (40) tick();
        check("glitch_count", count, 0);
        send_frame(8'h6B, 1'b1);
        check("glitch_after_count", count, 1);
        pop_check("glitch_after", 8'h6B);

        // table of single frames, including bad stop bits
        for (int i = 0; i < 6; i++) begin
            f0 = fe_seen;
            send_frame(tbl[i].val, tbl[i].stop);
            repeat (24) tick();
            check($sformatf("tbl%0d_count", i), count, 32'(tbl[i].exp_push));
            check($sformatf("tbl%0d_fe", i), fe_seen - f0,
                  tbl[i].stop ? 0 : BAD_STOP_FE);
            if (tbl[i].exp_push) pop_check($sformatf("tbl%0d", i), tbl[i].val);
        end

        // reset in the middle of a frame
        send_frame(8'h77, 1'b1);
        check("midrst_pre_count", count, 1);
        b = 8'h0F;
        rx_pin = 1'b0;
        repeat (BP) tick();
        for (int i = 0; i < 4; i++) begin
            rx_pin = b[i];
            repeat (BP) tick();
        end
        rx_pin = b[4];
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst_hold");
        repeat (2) tick();
        rx_pin = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check_reset_outputs("midrst_rel");
        send_frame(8'h55, 1'b1);
        repeat (8) tick();
        check("midrst_55_count", count, 1);
        pop_check("midrst_55", 8'h55);

        // randomized bursts against the queue model
        q.delete();
        for (int it = 0; it < 15; it++) begin
            o0 = ovr_seen;
            exp_ovr = 0;
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                send_frame(b, 1'b1);
                if (q.size() < D) q.push_back(b);
                else exp_ovr++;
            end
            check($sformatf("rnd%0d_count", it), count, q.size());
            check($sformatf("rnd%0d_ovr", it), ovr_seen - o0, exp_ovr);
            p = $urandom_range(0, q.size());
            for (int j = 0; j < p; j++) begin
                pop_check($sformatf("rnd%0d_pop", it), q.pop_front());
            end
            check($sformatf("rnd%0d_count_after", it), count, q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
